// File: rtl/i3c_tobus_fifo.sv
// i3c_tobus_fifo
// ----------------------------------------------------------------------------
// Transmit (to-bus) byte FIFO between the i3c_regs register block and the
// I3C bus engine. Software writes bytes through the register block. Each
// change of regflg_wr_cnt pushes one {end, data} entry. The bus engine reads
// the head entry (show-ahead) and pops it with tb_rd. Fill level, full and
// trigger status go back to i3c_regs. A push that cannot be stored is
// reported with a single-cycle tb_ovf pulse.
//
// Ports
//   PCLK             in  1  single clock, rising edge
//   PRESETn          in  1  synchronous active-low reset
//   regflg_wr_cnt    in  2  write-flag counter; any change is one push request
//   reg_wdata        in  8  byte to push
//   reg_TbEnd        in  1  end-of-message flag stored with the byte
//   reg_TbFlush      in  1  level flush request, empties the FIFO
//   reg_TxTrig       in  2  trigger-level select
//   tb_rd            in  1  pop strobe from the bus engine
//   tb_data          out 8  head byte, valid while tb_avail is 1
//   tb_end           out 1  end flag of the head entry
//   tb_avail         out 1  FIFO not empty
//   inp_TxCnt        out 5  entry count, 0..FIFO_DEPTH
//   inp_TxFull       out 1  count equals FIFO_DEPTH
//   tx_trig          out 1  count at or below the selected threshold
//   inp_dma_last_tb  out 1  pulse after an entry with end flag is popped
//   tb_ovf           out 1  pulse after a push is dropped on a full FIFO
// ----------------------------------------------------------------------------
module i3c_tobus_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 5
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [1:0]       regflg_wr_cnt,
    input  logic [7:0]       reg_wdata,
    input  logic             reg_TbEnd,
    input  logic             reg_TbFlush,
    input  logic [1:0]       reg_TxTrig,
    input  logic             tb_rd,
    output logic [7:0]       tb_data,
    output logic             tb_end,
    output logic             tb_avail,
    output logic [CNT_W-1:0] inp_TxCnt,
    output logic             inp_TxFull,
    output logic             tx_trig,
    output logic             inp_dma_last_tb,
    output logic             tb_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] THR_Q   = CNT_W'(FIFO_DEPTH / 4);
    localparam logic [CNT_W-1:0] THR_H   = CNT_W'(FIFO_DEPTH / 2);
    localparam logic [CNT_W-1:0] THR_F   = CNT_W'(FIFO_DEPTH - 1);

    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       wr_cnt_q;
    logic             last_q;
    logic             ovf_q;

    logic             push_req;
    logic             pop_ok;
    logic             push_ok;
    logic             empty;
    logic             full;
    logic [8:0]       head;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign push_req = (regflg_wr_cnt != wr_cnt_q);
    assign pop_ok   = tb_rd && !empty;
    // A full FIFO can still take a byte when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop_ok);
    assign head     = mem[rd_ptr];

    // Pointers, count and the single-cycle status pulses. Flush wins over any
    // push or pop in the same cycle and suppresses their side effects.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_cnt_q <= regflg_wr_cnt;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_cnt_q <= regflg_wr_cnt;
            if (reg_TbFlush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                last_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                last_q <= pop_ok && head[8];
                ovf_q  <= push_req && !push_ok;
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push_ok && !pop_ok) begin
                    count <= count + CNT_W'(1);
                end else if (pop_ok && !push_ok) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Entry storage needs no reset: contents are only visible while count > 0.
    always_ff @(posedge PCLK) begin
        if (PRESETn && !reg_TbFlush && push_ok) begin
            mem[wr_ptr] <= {reg_TbEnd, reg_wdata};
        end
    end

    // Trigger threshold decode.
    always_comb begin
        tx_trig = 1'b0;
        case (reg_TxTrig)
            2'd0:    tx_trig = (count == '0);
            2'd1:    tx_trig = (count <= THR_Q);
            2'd2:    tx_trig = (count <= THR_H);
            default: tx_trig = (count <= THR_F);
        endcase
    end

    assign tb_data         = head[7:0];
    assign tb_end          = head[8];
    assign tb_avail        = !empty;
    assign inp_TxCnt       = count;
    assign inp_TxFull      = full;
    assign inp_dma_last_tb = last_q;
    assign tb_ovf          = ovf_q;

endmodule

// File: tb/tb_i3c_tobus_fifo.sv
// tb_i3c_tobus_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for i3c_tobus_fifo. A queue-based reference model
// predicts the contents, status outputs and pulses after every clock edge.
// Directed scenarios are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_i3c_tobus_fifo;

    localparam int DEPTH = 8;

    logic       PCLK;
    logic       PRESETn;
    logic [1:0] regflg_wr_cnt;
    logic [7:0] reg_wdata;
    logic       reg_TbEnd;
    logic       reg_TbFlush;
    logic [1:0] reg_TxTrig;
    logic       tb_rd;
    logic [7:0] tb_data;
    logic       tb_end;
    logic       tb_avail;
    logic [4:0] inp_TxCnt;
    logic       inp_TxFull;
    logic       tx_trig;
    logic       inp_dma_last_tb;
    logic       tb_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [8:0] q[$];
    logic [1:0] m_prev_cnt;
    logic       m_last;
    logic       m_ovf;

    i3c_tobus_fifo #(.FIFO_DEPTH(DEPTH), .CNT_W(5)) dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .regflg_wr_cnt   (regflg_wr_cnt),
        .reg_wdata       (reg_wdata),
        .reg_TbEnd       (reg_TbEnd),
        .reg_TbFlush     (reg_TbFlush),
        .reg_TxTrig      (reg_TxTrig),
        .tb_rd           (tb_rd),
        .tb_data         (tb_data),
        .tb_end          (tb_end),
        .tb_avail        (tb_avail),
        .inp_TxCnt       (inp_TxCnt),
        .inp_TxFull      (inp_TxFull),
        .tx_trig         (tx_trig),
        .inp_dma_last_tb (inp_dma_last_tb),
        .tb_ovf          (tb_ovf)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_trig(input logic [1:0] sel, input int n);
        int thr;
        case (sel)
            2'd0:    thr = 0;
            2'd1:    thr = DEPTH / 4;
            2'd2:    thr = DEPTH / 2;
            default: thr = DEPTH - 1;
        endcase
        return (n <= thr);
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        logic push;
        logic pop;
        logic [8:0] popped;
        if (!PRESETn) begin
            q.delete();
            m_prev_cnt = regflg_wr_cnt;
            m_last = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            push = (regflg_wr_cnt != m_prev_cnt);
            m_prev_cnt = regflg_wr_cnt;
            if (reg_TbFlush) begin
                q.delete();
                m_last = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                pop    = tb_rd && (q.size() > 0);
                m_last = pop && q[0][8];
                m_ovf  = push && (q.size() == DEPTH) && !pop;
                if (pop) popped = q.pop_front();
                if (push && !m_ovf) q.push_back({reg_TbEnd, reg_wdata});
            end
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(inp_TxCnt), 32'(q.size()));
        check("avail", 32'(tb_avail), 32'(q.size() != 0));
        check("full",  32'(inp_TxFull), 32'(q.size() == DEPTH));
        check("trig",  32'(tx_trig), 32'(exp_trig(reg_TxTrig, q.size())));
        check("last",  32'(inp_dma_last_tb), 32'(m_last));
        check("ovf",   32'(tb_ovf), 32'(m_ovf));
        if (q.size() > 0) begin
            check("head_data", 32'(tb_data), 32'(q[0][7:0]));
            check("head_end",  32'(tb_end),  32'(q[0][8]));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge PCLK);
        #1;
        check_outputs();
        reg_TbFlush = 1'b0;
        tb_rd       = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic rd);
        regflg_wr_cnt = regflg_wr_cnt + 2'd1;
        reg_wdata     = d;
        reg_TbEnd     = e;
        tb_rd         = rd;
        tick();
    endtask

    task automatic pop();
        tb_rd = 1'b1;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) pop();
    endtask

    initial begin
        PRESETn       = 1'b0;
        regflg_wr_cnt = 2'd2;
        reg_wdata     = 8'h00;
        reg_TbEnd     = 1'b0;
        reg_TbFlush   = 1'b0;
        reg_TxTrig    = 2'd0;
        tb_rd         = 1'b0;
        m_prev_cnt    = 2'd0;
        m_last        = 1'b0;
        m_ovf         = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_trig", 32'(tx_trig), 32'd1);
        PRESETn = 1'b1;
        tick();

        // Three pushes and three pops, end flag on the last byte
        push(8'hA1, 1'b0, 1'b0);
        push(8'hB2, 1'b0, 1'b0);
        push(8'hC3, 1'b1, 1'b0);
        check("cnt3", 32'(inp_TxCnt), 32'd3);
        pop();
        pop();
        check("head_c3", 32'(tb_data), 32'hC3);
        pop();
        check("last_c3", 32'(inp_dma_last_tb), 32'd1);
        tick();

        // Fill, then overflow
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        check("ovf_pulse", 32'(tb_ovf), 32'd1);
        tick();

        // Full with simultaneous push and pop
        push(8'h77, 1'b1, 1'b1);
        check("full_pp_cnt", 32'(inp_TxCnt), 32'(DEPTH));
        drain();

        // Flush together with a push and a pop
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0, 1'b0);
        reg_TbFlush = 1'b1;
        push(8'hEE, 1'b0, 1'b1);
        check("flush_cnt", 32'(inp_TxCnt), 32'd0);
        push(8'h5A, 1'b0, 1'b0);
        check("after_flush", 32'(tb_data), 32'h5A);
        pop();

        // Trigger threshold sweep at counts 0, 2, 4, 7, 8
        for (int c = 0; c <= DEPTH; c++) begin
            if (c == 0 || c == 2 || c == 4 || c == 7 || c == 8) begin
                for (int t = 0; t < 4; t++) begin
                    reg_TxTrig = 2'(t);
                    tick();
                end
            end
            if (c < DEPTH) push(8'(c), 1'b0, 1'b0);
        end
        drain();

        // Sustained push+pop across pointer wrap
        push(8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) push(8'(8'h81 + i), 1'(i % 3 == 0), 1'b1);

        // Reset mid-stream while pushing
        PRESETn = 1'b0;
        push(8'h99, 1'b0, 1'b1);
        PRESETn = 1'b1;
        tick();

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0)
                regflg_wr_cnt = regflg_wr_cnt + 2'($urandom_range(1, 3));
            reg_wdata   = 8'($urandom);
            reg_TbEnd   = 1'($urandom);
            tb_rd       = ($urandom_range(0, 2) == 0);
            reg_TbFlush = ($urandom_range(0, 39) == 0);
            reg_TxTrig  = 2'($urandom);
            PRESETn     = ($urandom_range(0, 99) != 0);
            tick();
        end
        PRESETn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
